// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN image loader.
package snn_pkg;

  localparam int unsigned IMG_BYTES  = 98;
  localparam int unsigned IMG_BITS   = 784;
  localparam int unsigned IMG_ADDR_W = 10;
  localparam int unsigned CNT_W      = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    FULL   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/snn_byte_unpack.sv
// Byte load/shift register that serialises a byte LSB-first with a saturating bit index.
module snn_byte_unpack (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       bit_out,
  output logic [2:0] bit_idx,
  output logic       last
);

  logic [7:0] shift;

  // Index parks at 7 after a byte so idle outputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= 8'd0;
      bit_idx <= 3'd0;
    end else if (load) begin
      shift   <= din;
      bit_idx <= 3'd0;
    end else begin
      shift <= {1'b0, shift[7:1]};
      if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
    end
  end

  assign bit_out = shift[0];
  assign last    = (bit_idx == 3'd7);

endmodule

// File: rtl/snn_img_loader.sv
// Collects UART bytes of a binary image and unpacks them bit-serially into the SNN input RAM.
module snn_img_loader
  import snn_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = IMG_BYTES,
  parameter int unsigned ADDR_W      = IMG_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              img_ready,
  input  logic              img_ack,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  loader_state_t    state, state_d;
  logic             pend_vld, pend_vld_d;
  logic [7:0]       pend_data, pend_data_d;
  logic [CNT_W-1:0] byte_cnt_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             overrun_d, tmo_err_d;
  logic             load;
  logic [7:0]       load_data;
  logic             bit_out, last;
  logic [2:0]       bit_idx;

  snn_byte_unpack u_unpack (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (load_data),
    .bit_out (bit_out),
    .bit_idx (bit_idx),
    .last    (last)
  );

  assign ram_addr  = ADDR_W'({byte_cnt, bit_idx});
  assign ram_wdata = bit_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_vld    <= 1'b0;
      pend_data   <= 8'd0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      ram_we      <= 1'b0;
      img_ready   <= 1'b0;
    end else begin
      state       <= state_d;
      pend_vld    <= pend_vld_d;
      pend_data   <= pend_data_d;
      byte_cnt    <= byte_cnt_d;
      tmo_cnt     <= tmo_cnt_d;
      overrun     <= overrun_d;
      timeout_err <= tmo_err_d;
      ram_we      <= (state_d == UNPACK);
      img_ready   <= (state_d == FULL);
    end
  end

  always_comb begin
    state_d     = state;
    pend_vld_d  = pend_vld;
    pend_data_d = pend_data;
    byte_cnt_d  = byte_cnt;
    tmo_cnt_d   = '0;
    overrun_d   = overrun;
    tmo_err_d   = 1'b0;
    load        = 1'b0;
    load_data   = rx_data;

    unique case (state)
      IDLE: begin
        if (pend_vld) begin
          // Byte parked while busy (or on the ack cycle) starts first.
          load       = 1'b1;
          load_data  = pend_data;
          state_d    = UNPACK;
          pend_vld_d = 1'b0;
          if (rx_rdy) begin
            pend_vld_d  = 1'b1;
            pend_data_d = rx_data;
          end
        end else if (rx_rdy) begin
          load    = 1'b1;
          state_d = UNPACK;
        end else if (byte_cnt != '0 && byte_cnt < CNT_W'(NUM_BYTES)) begin
          if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            byte_cnt_d = '0;
            tmo_err_d  = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt + TMO_W'(1);
          end
        end
      end

      UNPACK: begin
        if (rx_rdy) begin
          if (pend_vld) begin
            overrun_d = 1'b1;
          end else begin
            pend_vld_d  = 1'b1;
            pend_data_d = rx_data;
          end
        end
        if (last) begin
          byte_cnt_d = byte_cnt + CNT_W'(1);
          if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
            // Image complete: anything queued behind it has nowhere to go.
            state_d    = FULL;
            pend_vld_d = 1'b0;
            if (pend_vld || rx_rdy) overrun_d = 1'b1;
          end else if (pend_vld) begin
            load       = 1'b1;
            load_data  = pend_data;
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      FULL: begin
        if (img_ack) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          if (rx_rdy) begin
            pend_vld_d  = 1'b1;
            pend_data_d = rx_data;
          end
        end else if (rx_rdy) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_snn_img_loader.sv
// Scoreboard bench for snn_img_loader: expected RAM writes are queued as bytes are sent.
module tb_snn_img_loader;

  localparam int unsigned TMO = 100;
  localparam int unsigned NB  = 98;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       img_ack;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_wdata;
  logic       img_ready;
  logic [6:0] byte_cnt;
  logic       overrun;
  logic       timeout_err;

  snn_img_loader #(
    .NUM_BYTES   (NB),
    .ADDR_W      (10),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .img_ready   (img_ready),
    .img_ack     (img_ack),
    .byte_cnt    (byte_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic       data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] pat(input int i, input int salt);
    int v;
    v = i * 73 + salt * 151 + 17;
    return 8'(v ^ (v >> 3));
  endfunction

  task automatic push_byte(input int idx, input logic [7:0] b);
    wr_t e;
    for (int j = 0; j < 8; j++) begin
      e.addr = 10'(8 * idx + j);
      e.data = b[j];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic rdy, input logic [7:0] b, input logic ack);
    @(posedge clk);
    #1;
    rx_rdy  = rdy;
    rx_data = b;
    img_ack = ack;
    @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
    img_ack = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int cnt, input int gap, input int salt);
    logic [7:0] b;
    for (int i = 0; i < cnt; i++) begin
      b = pat(first + i, salt);
      push_byte(first + i, b);
      pulse(1'b1, b, 1'b0);
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    rx_rdy  = 1'b0;
    img_ack = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (exp_q.size() == 0) begin
        check("unexp_wr", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
        check("wr_data", 32'(ram_wdata), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int n;
    rst     = 1'b1;
    rx_rdy  = 1'b0;
    rx_data = 8'd0;
    img_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(ram_we), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_ready", 32'(img_ready), 0);
    check("rst_cnt", 32'(byte_cnt), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_tmo", 32'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte: bits at addr 0..7 in t+1..t+8, count at t+9
    push_byte(0, 8'hA5);
    pulse(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("a5_we", 32'(ram_we), 1);
      check("a5_addr", 32'(ram_addr), 32'(k));
    end
    @(negedge clk);
    check("a5_cnt", 32'(byte_cnt), 1);
    check("a5_we_off", 32'(ram_we), 0);

    // Back-to-back bytes through the pending slot, third one overruns
    do_reset();
    push_byte(0, 8'hFF);
    push_byte(1, 8'h00);
    pulse(1'b1, 8'hFF, 1'b0);
    pulse(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("b2b_ovr0", 32'(overrun), 0);
    pulse(1'b1, 8'h77, 1'b0);
    @(negedge clk);
    check("b2b_ovr1", 32'(overrun), 1);
    repeat (3) @(negedge clk);
    check("b2b_addr7", 32'(ram_addr), 7);
    @(negedge clk);
    check("b2b_nogap_we", 32'(ram_we), 1);
    check("b2b_nogap_addr", 32'(ram_addr), 8);
    wait_drain("b2b_drain", 100);
    @(negedge clk);
    check("b2b_cnt", 32'(byte_cnt), 2);

    // Full image at a slow byte rate, then FULL-state behaviour
    do_reset();
    send_bytes(0, NB - 1, 29, 6);
    b = pat(NB - 1, 6);
    push_byte(NB - 1, b);
    pulse(1'b1, b, 1'b0);
    repeat (8) @(negedge clk);
    check("img_last_addr", 32'(ram_addr), 783);
    check("img_last_we", 32'(ram_we), 1);
    check("img_ready_early", 32'(img_ready), 0);
    @(negedge clk);
    check("img_ready", 32'(img_ready), 1);
    check("img_cnt", 32'(byte_cnt), 98);
    check("img_we_off", 32'(ram_we), 0);
    check("img_ovr0", 32'(overrun), 0);
    pulse(1'b1, 8'h55, 1'b0);
    @(negedge clk);
    check("full_ovr", 32'(overrun), 1);
    check("full_ready", 32'(img_ready), 1);
    check("full_cnt", 32'(byte_cnt), 98);
    repeat (10) @(negedge clk);
    pulse(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("ack_ready", 32'(img_ready), 0);
    check("ack_cnt", 32'(byte_cnt), 0);

    // Ack outside FULL ignored; ack together with a byte starts the next image
    do_reset();
    send_bytes(0, 50, 9, 7);
    pulse(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("ack_ign_cnt", 32'(byte_cnt), 50);
    send_bytes(50, NB - 50, 9, 7);
    wait_drain("img2_drain", 100);
    @(negedge clk);
    check("img2_ready", 32'(img_ready), 1);
    push_byte(0, 8'h3C);
    pulse(1'b1, 8'h3C, 1'b1);
    @(negedge clk);
    check("ackrx_ready", 32'(img_ready), 0);
    check("ackrx_cnt", 32'(byte_cnt), 0);
    check("ackrx_we_gap", 32'(ram_we), 0);
    @(negedge clk);
    check("ackrx_we", 32'(ram_we), 1);
    check("ackrx_addr", 32'(ram_addr), 0);
    wait_drain("ackrx_drain", 100);
    @(negedge clk);
    check("ackrx_cnt1", 32'(byte_cnt), 1);
    check("ackrx_ovr", 32'(overrun), 0);

    // Inter-byte timeout discards the partial image
    do_reset();
    send_bytes(0, 10, 9, 3);
    wait_drain("tmo_drain", 100);
    @(negedge clk);
    check("tmo_cnt10", 32'(byte_cnt), 10);
    n = 1;
    while (!timeout_err && n < 3 * TMO) begin
      @(negedge clk);
      n++;
    end
    check("tmo_seen", 32'(timeout_err), 1);
    check("tmo_delay", 32'(n >= TMO && n <= TMO + 2), 1);
    check("tmo_cnt0", 32'(byte_cnt), 0);
    @(negedge clk);
    check("tmo_pulse_len", 32'(timeout_err), 0);
    push_byte(0, 8'hC3);
    pulse(1'b1, 8'hC3, 1'b0);
    wait_drain("tmo_next_drain", 100);
    @(negedge clk);
    check("tmo_next_cnt", 32'(byte_cnt), 1);

    // Reset mid-unpack, then a clean full image
    do_reset();
    send_bytes(0, 5, 9, 4);
    b = pat(5, 4);
    push_byte(5, b);
    pulse(1'b1, b, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_addr", 32'(ram_addr), 44);
    check("mid_we", 32'(ram_we), 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(ram_we), 0);
    check("mid_rst_addr", 32'(ram_addr), 0);
    check("mid_rst_wdata", 32'(ram_wdata), 0);
    check("mid_rst_ready", 32'(img_ready), 0);
    check("mid_rst_cnt", 32'(byte_cnt), 0);
    check("mid_rst_ovr", 32'(overrun), 0);
    check("mid_rst_tmo", 32'(timeout_err), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_bytes(0, NB, 9, 5);
    wait_drain("post_rst_drain", 100);
    @(negedge clk);
    check("post_rst_ready", 32'(img_ready), 1);
    check("post_rst_cnt", 32'(byte_cnt), 98);
    check("post_rst_ovr", 32'(overrun), 0);

    check("q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
